// File: rtl/fu_shift_pkg.sv
// fu_shift_pkg: shared definitions for the shift/rotate functional unit.
//   OP_*          : 2-bit operation encodings carried on the op port
//   state_e       : control FSM state encoding (IDLE / BUSY / HOLD)
//   shamt_width() : number of shift-amount bits (= barrel stages) for a width
package fu_shift_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b11;
  localparam logic [1:0] OP_ROR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic int shamt_width(input int data_width);
    return $clog2(data_width);
  endfunction

endpackage

// File: rtl/fu_shift_stage.sv
// fu_shift_stage: one combinational barrel stage. Shifts/rotates by
// 2**STAGE_INDEX when amt_bit_i is set, otherwise passes data through.
//   data_i    : value entering this stage
//   op_i      : operation (SLL / SRL / SRA / ROR)
//   amt_bit_i : shift-amount bit STAGE_INDEX
//   data_o    : value leaving this stage
module fu_shift_stage
  import fu_shift_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int STAGE_INDEX = 0
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [1:0]            op_i,
  input  logic                  amt_bit_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam int SH = 1 << STAGE_INDEX;

  logic [DATA_WIDTH-1:0] shifted;

  always_comb begin
    shifted = data_i;
    case (op_i)
      OP_SLL:  shifted = data_i << SH;
      OP_SRL:  shifted = data_i >> SH;
      // The running value keeps the original sign bit in its MSB, so each
      // stage can replicate its own MSB and the composition stays correct.
      OP_SRA:  shifted = DATA_WIDTH'($signed(data_i) >>> SH);
      OP_ROR:  shifted = {data_i[SH-1:0], data_i[DATA_WIDTH-1:SH]};
      default: shifted = data_i;
    endcase
  end

  assign data_o = amt_bit_i ? shifted : data_i;

endmodule

// File: rtl/fu_shift.sv
// fu_shift: pipelined shift/rotate functional unit (SLL, SRL, SRA, ROR).
//   clk, rst_n        : clock, asynchronous active-low reset
//   ce                : dispatch strobe (accepted only when the unit can take work)
//   op                : operation select
//   executionTag_in   : tag of the dispatched instruction
//   data_0            : shift amount (low log2(DATA_WIDTH) bits used)
//   data_1            : value to shift
//   queued            : broadcast queue accepted the held result
//   idle              : unit can accept a dispatch this cycle
//   result            : registered result, held until the next done
//   done              : one-cycle pulse when result becomes valid
//   executionTag_out  : tag belonging to the held result
//
// Operands are registered on the accepting edge; the barrel stages are split
// into LATENCY groups with a register after each, the last group feeding the
// result register, so done rises LATENCY edges after the accepting edge.
module fu_shift
  import fu_shift_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1,
  parameter int TAG_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic [1:0]            op,
  input  logic [TAG_WIDTH-1:0]  executionTag_in,
  input  logic [DATA_WIDTH-1:0] data_0,
  input  logic [DATA_WIDTH-1:0] data_1,
  input  logic                  queued,
  output logic                  idle,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  done,
  output logic [TAG_WIDTH-1:0]  executionTag_out
);

  localparam int SW  = shamt_width(DATA_WIDTH);
  localparam int PER = (SW + LATENCY - 1) / LATENCY;   // stages per cycle
  localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

  state_e                             state_q;
  logic [CW-1:0]                      cnt_q;
  logic [LATENCY-1:0][DATA_WIDTH-1:0] pipe_data_q;
  logic [LATENCY-1:0][1:0]            pipe_op_q;
  logic [LATENCY-1:0][SW-1:0]         pipe_amt_q;
  logic [DATA_WIDTH-1:0]              result_q;
  logic                               done_q;
  logic [TAG_WIDTH-1:0]               tag_q;

  logic [DATA_WIDTH-1:0] stage_in  [SW];
  logic [DATA_WIDTH-1:0] stage_out [SW];
  logic [DATA_WIDTH-1:0] group_out [LATENCY];

  logic can_accept;
  logic accept;
  logic unused_bits;

  // A held result may be replaced in the same cycle the queue takes it.
  assign can_accept = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && queued);
  assign accept     = ce && can_accept;
  assign idle       = can_accept && !ce;

  // Upper amount bits are discarded (mod DATA_WIDTH); some per-group op and
  // amount bits are never consumed by the stages of that group.
  assign unused_bits = ^{data_0[DATA_WIDTH-1:SW], pipe_op_q, pipe_amt_q};

  // Barrel stages: the first stage of each group reads that group's register,
  // the rest chain combinationally.
  for (genvar gi = 0; gi < SW; gi++) begin : g_stage
    localparam int GRP = gi / PER;
    if (gi % PER == 0) begin : g_head
      assign stage_in[gi] = pipe_data_q[GRP];
    end else begin : g_chain
      assign stage_in[gi] = stage_out[gi-1];
    end
    fu_shift_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .STAGE_INDEX(gi)
    ) u_stage (
      .data_i   (stage_in[gi]),
      .op_i     (pipe_op_q[GRP]),
      .amt_bit_i(pipe_amt_q[GRP][gi]),
      .data_o   (stage_out[gi])
    );
  end

  // Group outputs; a group left without stages simply forwards its register.
  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_group
    localparam int FIRST  = gi * PER;
    localparam int LAST_S = (((gi + 1) * PER < SW) ? (gi + 1) * PER : SW) - 1;
    if (FIRST > LAST_S) begin : g_empty
      assign group_out[gi] = pipe_data_q[gi];
    end else begin : g_tail
      assign group_out[gi] = stage_out[LAST_S];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pipe_data_q <= '0;
      pipe_op_q   <= '0;
      pipe_amt_q  <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
      tag_q       <= '0;
    end else begin
      done_q <= 1'b0;

      if (state_q == ST_BUSY) begin
        for (int g = 1; g < LATENCY; g++) begin
          pipe_data_q[g] <= group_out[g-1];
          pipe_op_q[g]   <= pipe_op_q[g-1];
          pipe_amt_q[g]  <= pipe_amt_q[g-1];
        end
      end

      if (accept) begin
        pipe_data_q[0] <= data_1;
        pipe_op_q[0]   <= op;
        pipe_amt_q[0]  <= data_0[SW-1:0];
        tag_q          <= executionTag_in;
        cnt_q          <= '0;
        state_q        <= ST_BUSY;
      end else begin
        case (state_q)
          ST_BUSY: begin
            if (cnt_q == CNT_LAST) begin
              result_q <= group_out[LATENCY-1];
              done_q   <= 1'b1;
              state_q  <= ST_HOLD;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          ST_HOLD: begin
            if (queued) begin
              state_q <= ST_IDLE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign result           = result_q;
  assign done             = done_q;
  assign executionTag_out = tag_q;

endmodule

// File: tb/tb_fu_shift.sv
module tb_fu_shift;
  import fu_shift_pkg::*;

  localparam int DW = 32;
  localparam int TW = 7;
  localparam int NU = 3;

  typedef struct packed {
    logic [DW-1:0] res;
    logic [TW-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n_s  [NU];
  logic          ce_s     [NU];
  logic          queued_s [NU];
  logic          idle_s   [NU];
  logic          done_s   [NU];
  logic [DW-1:0] result_s [NU];
  logic [TW-1:0] tag_s    [NU];
  logic [1:0]    op;
  logic [DW-1:0] data_0;
  logic [DW-1:0] data_1;
  logic [TW-1:0] tag_in;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  function automatic int lat_of(input int u);
    case (u)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  for (genvar gi = 0; gi < NU; gi++) begin : g_dut
    fu_shift #(
      .DATA_WIDTH(DW),
      .LATENCY   (lat_of(gi)),
      .TAG_WIDTH (TW)
    ) u_dut (
      .clk             (clk),
      .rst_n           (rst_n_s[gi]),
      .ce              (ce_s[gi]),
      .op              (op),
      .executionTag_in (tag_in),
      .data_0          (data_0),
      .data_1          (data_1),
      .queued          (queued_s[gi]),
      .idle            (idle_s[gi]),
      .result          (result_s[gi]),
      .done            (done_s[gi]),
      .executionTag_out(tag_s[gi])
    );
  end

  // Reference: plain shift operators, rotate via a doubled word.
  function automatic logic [DW-1:0] model(input logic [1:0] o, input logic [DW-1:0] d1,
                                          input logic [DW-1:0] d0);
    int a;
    logic [2*DW-1:0] dbl;
    a   = int'(d0[4:0]);
    dbl = {d1, d1};
    case (o)
      2'b00:   return d1 << a;
      2'b01:   return d1 >> a;
      2'b11:   return DW'($signed(d1) >>> a);
      default: return dbl[a +: DW];
    endcase
  endfunction

  function automatic int qsize(input int u);
    case (u)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push_exp(input int u, input exp_t e);
    case (u)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int u, output exp_t e);
    case (u)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic clear_exp(input int u);
    case (u)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  // Scoreboard: every done cycle must match the oldest outstanding dispatch.
  always @(negedge clk) begin
    for (int u = 0; u < NU; u++) begin
      if (done_s[u] === 1'b1) begin
        exp_t e;
        checks++;
        if (qsize(u) == 0) begin
          errors++;
          $display("FAIL sb_unexpected_done unit %0d: got result %h tag %h, required no done",
                   u, result_s[u], tag_s[u]);
        end else begin
          pop_exp(u, e);
          if (result_s[u] !== e.res || tag_s[u] !== e.tag) begin
            errors++;
            $display("FAIL sb_result unit %0d: got %h/%h required %h/%h",
                     u, result_s[u], tag_s[u], e.res, e.tag);
          end else begin
            $display("unit %0d done result %h tag %h", u, result_s[u], tag_s[u]);
          end
        end
      end
    end
  end

  task automatic dispatch(input int u, input logic [1:0] o, input logic [DW-1:0] d1,
                          input logic [DW-1:0] d0, input logic [TW-1:0] t);
    exp_t e;
    op         = o;
    data_1     = d1;
    data_0     = d0;
    tag_in     = t;
    ce_s[u]    = 1'b1;
    e.res      = model(o, d1, d0);
    e.tag      = t;
    push_exp(u, e);
    @(posedge clk);
    #1;
    ce_s[u] = 1'b0;
  endtask

  // Edges from now until done is seen; -1 when the bound expires.
  task automatic wait_done(input int u, output int cycles);
    cycles = 0;
    while (done_s[u] !== 1'b1 && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (done_s[u] !== 1'b1) cycles = -1;
  endtask

  task automatic ack(input int u);
    queued_s[u] = 1'b1;
    @(posedge clk);
    #1;
    queued_s[u] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < NU; u++) begin
      checks++;
      if (result_s[u] !== '0) begin
        errors++;
        $display("FAIL reset_result unit %0d: got %h required 0", u, result_s[u]);
      end
      checks++;
      if (done_s[u] !== 1'b0 || tag_s[u] !== '0) begin
        errors++;
        $display("FAIL reset_done_tag unit %0d: got %b/%h required 0/0", u, done_s[u], tag_s[u]);
      end
      checks++;
      if (idle_s[u] !== 1'b1) begin
        errors++;
        $display("FAIL reset_idle unit %0d: got %b required 1", u, idle_s[u]);
      end
    end
    for (int u = 0; u < NU; u++) rst_n_s[u] = 1'b1;
    @(posedge clk);
    #1;
    for (int u = 0; u < NU; u++) begin
      checks++;
      if (idle_s[u] !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_idle unit %0d: got %b required 1", u, idle_s[u]);
      end
    end
    $display("reset test complete");
  endtask

  task automatic test_lat1_srl();
    int cyc;
    dispatch(0, OP_SRL, 32'h8000_0000, 32'd4, 7'h15);
    checks++;
    if (done_s[0] !== 1'b0 || idle_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL lat1_dispatch_cycle: got done %b idle %b required 0/0", done_s[0], idle_s[0]);
    end
    wait_done(0, cyc);
    checks++;
    if (cyc != 1) begin
      errors++;
      $display("FAIL lat1_latency: got %0d required 1", cyc);
    end
    checks++;
    if (result_s[0] !== 32'h0800_0000 || tag_s[0] !== 7'h15) begin
      errors++;
      $display("FAIL lat1_result: got %h/%h required 08000000/15", result_s[0], tag_s[0]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done_s[0] !== 1'b0 || idle_s[0] !== 1'b0 || result_s[0] !== 32'h0800_0000) begin
      errors++;
      $display("FAIL lat1_hold: got done %b idle %b result %h required 0/0/08000000",
               done_s[0], idle_s[0], result_s[0]);
    end
    queued_s[0] = 1'b1;
    #1;
    checks++;
    if (idle_s[0] !== 1'b1) begin
      errors++;
      $display("FAIL lat1_idle_on_queued: got %b required 1", idle_s[0]);
    end
    @(posedge clk);
    #1;
    queued_s[0] = 1'b0;
    #1;
    checks++;
    if (idle_s[0] !== 1'b1 || done_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL lat1_back_idle: got idle %b done %b required 1/0", idle_s[0], done_s[0]);
    end
    $display("lat1 srl test complete");
  endtask

  task automatic test_sra_sll();
    int cyc;
    dispatch(1, OP_SRA, 32'hF000_0000, 32'h24, 7'h2A);
    wait_done(1, cyc);
    checks++;
    if (cyc != 3 || result_s[1] !== 32'hFF00_0000) begin
      errors++;
      $display("FAIL sra_masked: got cyc %0d result %h required 3/ff000000", cyc, result_s[1]);
    end
    ack(1);
    dispatch(1, OP_SLL, 32'h1, 32'd31, 7'h01);
    wait_done(1, cyc);
    checks++;
    if (cyc != 3 || result_s[1] !== 32'h8000_0000) begin
      errors++;
      $display("FAIL sll_31: got cyc %0d result %h required 3/80000000", cyc, result_s[1]);
    end
    ack(1);
    $display("sra/sll test complete");
  endtask

  task automatic test_ror_zero();
    int cyc;
    logic [1:0] ops [4];
    ops[0] = OP_SLL; ops[1] = OP_SRL; ops[2] = OP_SRA; ops[3] = OP_ROR;
    dispatch(0, OP_ROR, 32'h0000_00F1, 32'd4, 7'h33);
    wait_done(0, cyc);
    checks++;
    if (cyc != 1 || result_s[0] !== 32'h1000_000F) begin
      errors++;
      $display("FAIL ror_4: got cyc %0d result %h required 1/1000000f", cyc, result_s[0]);
    end
    ack(0);
    for (int i = 0; i < 4; i++) begin
      // Amount 32 masks down to 0 as well.
      dispatch(2, ops[i], 32'hA5C3_0F81, (i % 2 == 1) ? 32'd32 : 32'd0, TW'(7'h40 + i));
      wait_done(2, cyc);
      checks++;
      if (cyc != 4 || result_s[2] !== 32'hA5C3_0F81) begin
        errors++;
        $display("FAIL zero_amount op %b: got cyc %0d result %h required 4/a5c30f81",
                 ops[i], cyc, result_s[2]);
      end
      ack(2);
    end
    $display("ror/zero-amount test complete");
  endtask

  task automatic test_back_to_back();
    int cyc;
    exp_t e;
    dispatch(1, OP_SRL, 32'hFFFF_0000, 32'd8, 7'h11);
    wait_done(1, cyc);
    checks++;
    if (cyc != 3 || result_s[1] !== 32'h00FF_FF00) begin
      errors++;
      $display("FAIL b2b_first: got cyc %0d result %h required 3/00ffff00", cyc, result_s[1]);
    end
    @(posedge clk);
    #1;
    queued_s[1] = 1'b1;
    #1;
    checks++;
    if (idle_s[1] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle_queued: got %b required 1", idle_s[1]);
    end
    op       = OP_SLL;
    data_1   = 32'h0000_00AB;
    data_0   = 32'd12;
    tag_in   = 7'h22;
    ce_s[1]  = 1'b1;
    e.res    = model(OP_SLL, 32'h0000_00AB, 32'd12);
    e.tag    = 7'h22;
    push_exp(1, e);
    #1;
    checks++;
    if (idle_s[1] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gated: got %b required 0", idle_s[1]);
    end
    @(posedge clk);
    #1;
    ce_s[1]     = 1'b0;
    queued_s[1] = 1'b0;
    checks++;
    if (done_s[1] !== 1'b0 || result_s[1] !== 32'h00FF_FF00 || tag_s[1] !== 7'h22) begin
      errors++;
      $display("FAIL b2b_old_held: got done %b result %h tag %h required 0/00ffff00/22",
               done_s[1], result_s[1], tag_s[1]);
    end
    wait_done(1, cyc);
    checks++;
    if (cyc != 3 || result_s[1] !== 32'h000A_B000 || tag_s[1] !== 7'h22) begin
      errors++;
      $display("FAIL b2b_second: got cyc %0d result %h tag %h required 3/000ab000/22",
               cyc, result_s[1], tag_s[1]);
    end
    ack(1);
    $display("back-to-back test complete");
  endtask

  task automatic test_ce_while_busy();
    int cyc;
    dispatch(2, OP_SRA, 32'h8000_0001, 32'd1, 7'h44);
    op       = OP_SLL;
    data_1   = 32'h0000_1234;
    data_0   = 32'd3;
    tag_in   = 7'h55;
    ce_s[2]  = 1'b1;
    #1;
    checks++;
    if (idle_s[2] !== 1'b0) begin
      errors++;
      $display("FAIL busy_ce_idle: got %b required 0", idle_s[2]);
    end
    @(posedge clk);
    #1;
    ce_s[2] = 1'b0;
    wait_done(2, cyc);
    checks++;
    if (cyc != 3 || result_s[2] !== 32'hC000_0000 || tag_s[2] !== 7'h44) begin
      errors++;
      $display("FAIL busy_ce_ignored: got cyc %0d result %h tag %h required 3/c0000000/44",
               cyc, result_s[2], tag_s[2]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done_s[2] !== 1'b0) begin
      errors++;
      $display("FAIL busy_ce_single_done: got %b required 0", done_s[2]);
    end
    ack(2);
    $display("ce-while-busy test complete");
  endtask

  task automatic test_reset_mid_busy();
    int seen;
    dispatch(2, OP_ROR, 32'h1234_5678, 32'd8, 7'h66);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n_s[2] = 1'b0;
    clear_exp(2);
    #1;
    checks++;
    if (result_s[2] !== '0 || done_s[2] !== 1'b0 || tag_s[2] !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h/%b/%h required 0/0/0",
               result_s[2], done_s[2], tag_s[2]);
    end
    @(posedge clk);
    #1;
    rst_n_s[2] = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (idle_s[2] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_idle: got %b required 1", idle_s[2]);
    end
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done_s[2] === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midreset_no_done: got %0d done pulses required 0", seen);
    end
    $display("reset-mid-busy test complete");
  endtask

  task automatic test_random();
    int cyc;
    int u;
    for (int i = 0; i < 24; i++) begin
      u = $urandom_range(0, NU - 1);
      dispatch(u, 2'($urandom_range(0, 3)), $urandom, $urandom, 7'($urandom));
      wait_done(u, cyc);
      checks++;
      if (cyc != lat_of(u)) begin
        errors++;
        $display("FAIL random_latency unit %0d: got %0d required %0d", u, cyc, lat_of(u));
      end
      ack(u);
    end
    $display("random test complete");
  endtask

  initial begin
    for (int u = 0; u < NU; u++) begin
      rst_n_s[u]  = 1'b0;
      ce_s[u]     = 1'b0;
      queued_s[u] = 1'b0;
    end
    op     = 2'b00;
    data_0 = '0;
    data_1 = '0;
    tag_in = '0;

    test_reset();
    test_lat1_srl();
    test_sra_sll();
    test_ror_zero();
    test_back_to_back();
    test_ce_while_busy();
    test_reset_mid_busy();
    test_random();

    repeat (2) @(posedge clk);
    for (int u = 0; u < NU; u++) begin
      checks++;
      if (qsize(u) != 0) begin
        errors++;
        $display("FAIL outstanding unit %0d: got %0d pending results required 0", u, qsize(u));
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
